// File: rtl/xor_check_pkg.sv
// ============================================================================
// Module  : xor_check_pkg
// Brief   : Shared types and constants for the XOR gate stimulus checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;

    // Golden response for a vector {a,b}
    function automatic logic ref_z(input logic [VEC_W-1:0] vec);
        return vec[1] ^ vec[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/xor_stim_checker_settle_timer.sv
// ============================================================================
// Module  : settle_timer
// Brief   : Loadable down-counter; expired_o is high once SETTLE_CYCLES-1
//           decrements have elapsed since the last load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expired_o
);

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/xor_stim_checker.sv
// ============================================================================
// Module  : xor_stim_checker
// Brief   : Clocked stimulus sequencer and checker for a two-input XOR gate.
//           Optional first-fail capture when XOR_CHECK_FIRST_FAIL_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_stim_checker
    import xor_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int ROUNDS        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [VEC_W-1:0] vec_idx
`ifdef XOR_CHECK_FIRST_FAIL_EN
    ,
    output logic             ff_valid,
    output logic [VEC_W-1:0] ff_vec
`endif
);

    localparam int               RW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0]    LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    state_e           state_q,  state_d;
    logic [VEC_W-1:0] vec_q,    vec_d;
    logic [RW-1:0]    round_q,  round_d;
    logic [CNT_W-1:0] err_q,    err_d;
    logic             timer_load;
    logic             timer_expired;
    logic             mismatch;

`ifdef XOR_CHECK_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [VEC_W-1:0] ff_vec_q,   ff_vec_d;
`endif

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .expired_o(timer_expired)
    );

    // a/b are the vector register itself, so z is judged against what is driven
    assign mismatch = (z != ref_z(vec_q));

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        round_d    = round_q;
        err_d      = err_q;
        timer_load = 1'b0;
`ifdef XOR_CHECK_FIRST_FAIL_EN
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    vec_d      = '0;
                    round_d    = '0;
                    err_d      = '0;
                    timer_load = 1'b1;
`ifdef XOR_CHECK_FIRST_FAIL_EN
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
`endif
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch && (err_q != ERR_MAX)) begin
                    err_d = err_q + CNT_W'(1);
                end
`ifdef XOR_CHECK_FIRST_FAIL_EN
                if (mismatch && !ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_vec_d   = vec_q;
                end
`endif
                if ((vec_q == LAST_VEC) && (round_q == LAST_ROUND)) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    vec_d      = vec_q + VEC_W'(1);
                    timer_load = 1'b1;
                    if (vec_q == LAST_VEC) begin
                        round_d = round_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            round_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            round_q <= round_d;
            err_q   <= err_d;
        end
    end

`ifdef XOR_CHECK_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    assign ff_valid = ff_valid_q;
    assign ff_vec   = ff_vec_q;
`endif

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;

endmodule

`default_nettype wire
